// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch/display slice:
//   - state_t        : stopwatch FSM states (IDLE/RUN/PAUSE/DONE), 2 bits
//   - SEG_*          : active-low 7-segment patterns {g..a} for digits 0-9
//   - SEG_BLANK      : all segments off
//   - MAX_COUNT      : terminal BCD count 999.9
//   - bcd_inc()      : increments a 4-digit packed BCD value, rippling the carry
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [15:0] MAX_COUNT = 16'h9999;

    // Add one to {D3,D2,D1,D0}; a digit at 9 rolls to 0 and passes the carry up.
    // 9999 rolls over to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg
// Combinational BCD digit to active-low 7-segment decoder.
// Ports:
//   bcd_i [3:0] : BCD digit; values 10-15 decode to blank
//   seg_o [6:0] : segments {g..a}, active-low
module bcd_to_seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// stopwatch_display
// Tenths-of-second BCD stopwatch (000.0-999.9) with a time-multiplexed,
// active-low 4-digit 7-segment display driver.
// Configuration macro: STOPWATCH_WRAP_EN
//   defined   : a tick at 9999 in RUN wraps to 0000 and keeps running
//   undefined : a tick at 9999 in RUN holds 9999 and enters DONE
// Parameters:
//   SCAN_BITS : width of the free-running scan counter; top 2 bits pick the digit
// Ports:
//   clk         : system clock
//   rst_n       : synchronous active-low reset
//   start_pulse : one-cycle pulse, toggles run/pause
//   clear_pulse : one-cycle pulse, back to IDLE with count zero (highest priority)
//   tick        : one-cycle 0.1 s enable
//   count_bcd   : {D3,D2,D1,D0} registered BCD count, D0 = tenths
//   running     : high while in RUN
//   an          : digit anodes, active-low one-hot
//   seg         : segments {g..a}, active-low
//   dp          : decimal point, active-low, lit on digit 1 only
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_BITS = 19
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_pulse,
    input  logic        clear_pulse,
    input  logic        tick,
    output logic [15:0] count_bcd,
    output logic        running,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    state_t               state_q, state_d;
    logic [15:0]          count_q, count_d;
    logic                 running_q;
    logic [SCAN_BITS-1:0] scan_q;
    logic [3:0]           an_q;
    logic [6:0]           seg_q;
    logic                 dp_q;

    logic [1:0]           digit_idx;
    logic [3:0]           digit_val;
    logic [6:0]           digit_seg;

    // Next-state / next-count. Transitions are decided from the current state,
    // so a tick and a start in the same RUN cycle both take effect.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clear_pulse) begin
            state_d = ST_IDLE;
            count_d = 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = 16'h0000;
                    if (start_pulse) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (start_pulse) state_d = ST_PAUSE;
                    if (tick) begin
                        if (count_q == MAX_COUNT) begin
`ifdef STOPWATCH_WRAP_EN
                            count_d = 16'h0000;
`else
                            // Reaching the end wins over a coincident pause.
                            count_d = MAX_COUNT;
                            state_d = ST_DONE;
`endif
                        end else begin
                            count_d = bcd_inc(count_q);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_pulse) state_d = ST_RUN;
                end
                ST_DONE: begin
                    count_d = MAX_COUNT;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = 16'h0000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= 16'h0000;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    // Display scan: the digit shown is picked by the current scan counter and
    // registered, so an/seg/dp trail the scan counter by one cycle.
    assign digit_idx = scan_q[SCAN_BITS-1 -: 2];

    always_comb begin
        digit_val = count_q[3:0];
        case (digit_idx)
            2'd0:    digit_val = count_q[3:0];
            2'd1:    digit_val = count_q[7:4];
            2'd2:    digit_val = count_q[11:8];
            2'd3:    digit_val = count_q[15:12];
            default: digit_val = count_q[3:0];
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd_i (digit_val),
        .seg_o (digit_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_q <= '0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            scan_q <= scan_q + {{(SCAN_BITS-1){1'b0}}, 1'b1};
            an_q   <= ~(4'b0001 << digit_idx);
            seg_q  <= digit_seg;
            dp_q   <= (digit_idx != 2'd1);
        end
    end

    assign count_bcd = count_q;
    assign running   = running_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;

endmodule
